// File: rtl/control_unit.sv
// Multicycle main controller for the CPU datapath.
// Moore FSM: fetch, decode, then one execute/memory/writeback path per
// instruction class, plus a two-state exception sequence (EPC save, vector).
module control_unit #(
  parameter int MEM_WAIT = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       overflow,
  input  logic       eq,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ABWrite,
  output logic       ALUOutControl,
  output logic       MDRWrite,
  output logic       EPCWrite,
  output logic [2:0] ALU_Control,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       RegDst,
  output logic       DataSrc,
  output logic [1:0] SSControl,
  output logic       exc_sel,
  output logic [4:0] state_out
);

  typedef enum logic [4:0] {
    FETCH   = 5'd0,
    WAIT    = 5'd1,
    IR_LOAD = 5'd2,
    DECODE  = 5'd3,
    R_EXEC  = 5'd4,
    R_WB    = 5'd5,
    I_EXEC  = 5'd6,
    I_WB    = 5'd7,
    ADDR    = 5'd8,
    LW_RD   = 5'd9,
    LW_WAIT = 5'd10,
    LW_MDR  = 5'd11,
    LW_WB   = 5'd12,
    SW_WR   = 5'd13,
    BRANCH  = 5'd14,
    JUMP    = 5'd15,
    EXC_EPC = 5'd16,
    EXC_JMP = 5'd17
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_CMP = 3'b111;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  // Last count value of a memory wait window; unused when MEM_WAIT is 0.
  localparam logic [1:0] WAIT_LAST = 2'((MEM_WAIT > 0) ? (MEM_WAIT - 1) : 0);
  localparam bit         SKIP_WAIT = (MEM_WAIT == 0);

  state_t     state_q;
  state_t     state_d;
  logic [1:0] wait_cnt;
  logic       wait_done;
  logic       r_arith;
  logic       r_valid;
  logic       br_taken;
  logic       ovf_trap;
  logic       bad_op;

  assign wait_done = (wait_cnt == WAIT_LAST);
  assign r_arith   = (funct == FN_ADD) || (funct == FN_SUB);
  assign r_valid   = r_arith || (funct == FN_AND);
  assign br_taken  = ((opcode == OP_BEQ) && eq) || ((opcode == OP_BNE) && !eq);
  // Only add/sub in R_EXEC and addi in I_EXEC may trap; and never traps.
  assign ovf_trap  = overflow && (((state_q == R_EXEC) && r_arith) || (state_q == I_EXEC));
  assign bad_op    = (state_q == DECODE) && (state_d == EXC_EPC);
  assign state_out = state_q;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Memory wait counter: runs only inside WAIT / LW_WAIT, cleared elsewhere
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                         wait_cnt <= 2'd0;
    else if ((state_q == WAIT) || (state_q == LW_WAIT)) wait_cnt <= wait_done ? 2'd0 : wait_cnt + 2'd1;
    else                                               wait_cnt <= 2'd0;
  end

  // Exception cause latch: invalid opcode clears it, arithmetic overflow sets it
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         exc_sel <= 1'b0;
    else if (bad_op)   exc_sel <= 1'b0;
    else if (ovf_trap) exc_sel <= 1'b1;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = SKIP_WAIT ? IR_LOAD : WAIT;
      WAIT:    state_d = wait_done ? IR_LOAD : WAIT;
      IR_LOAD: state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_R:           state_d = r_valid ? R_EXEC : EXC_EPC;
          OP_ADDI:        state_d = I_EXEC;
          OP_LW, OP_SW:   state_d = ADDR;
          OP_BEQ, OP_BNE: state_d = BRANCH;
          OP_J:           state_d = JUMP;
          default:        state_d = EXC_EPC;
        endcase
      end
      R_EXEC:  state_d = ovf_trap ? EXC_EPC : R_WB;
      R_WB:    state_d = FETCH;
      I_EXEC:  state_d = ovf_trap ? EXC_EPC : I_WB;
      I_WB:    state_d = FETCH;
      ADDR:    state_d = (opcode == OP_SW) ? SW_WR : LW_RD;
      LW_RD:   state_d = SKIP_WAIT ? LW_MDR : LW_WAIT;
      LW_WAIT: state_d = wait_done ? LW_MDR : LW_WAIT;
      LW_MDR:  state_d = LW_WB;
      LW_WB:   state_d = FETCH;
      SW_WR:   state_d = FETCH;
      BRANCH:  state_d = FETCH;
      JUMP:    state_d = FETCH;
      EXC_EPC: state_d = EXC_JMP;
      EXC_JMP: state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Output decode from state (eq/opcode only matter in BRANCH); all zero in reset
  always_comb begin
    PCWrite       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    ABWrite       = 1'b0;
    ALUOutControl = 1'b0;
    MDRWrite      = 1'b0;
    EPCWrite      = 1'b0;
    ALU_Control   = 3'b000;
    IorD          = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    PCSource      = 2'b00;
    RegDst        = 1'b0;
    DataSrc       = 1'b0;
    SSControl     = 2'b00;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          ALUSrcB     = 2'b01;
          ALU_Control = ALU_ADD;
          PCWrite     = 1'b1;
        end
        IR_LOAD: IRWrite = 1'b1;
        DECODE: begin
          ABWrite       = 1'b1;
          ALUOutControl = 1'b1;
          ALUSrcB       = 2'b11;
          ALU_Control   = ALU_ADD;
        end
        R_EXEC: begin
          ALUSrcA       = 1'b1;
          ALUOutControl = 1'b1;
          case (funct)
            FN_SUB:  ALU_Control = ALU_SUB;
            FN_AND:  ALU_Control = ALU_AND;
            default: ALU_Control = ALU_ADD;
          endcase
        end
        R_WB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        I_EXEC, ADDR: begin
          ALUSrcA       = 1'b1;
          ALUSrcB       = 2'b10;
          ALU_Control   = ALU_ADD;
          ALUOutControl = 1'b1;
        end
        I_WB: RegWrite = 1'b1;
        LW_RD, LW_WAIT: IorD = 1'b1;
        LW_MDR: MDRWrite = 1'b1;
        LW_WB: begin
          DataSrc  = 1'b1;
          RegWrite = 1'b1;
        end
        SW_WR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALU_Control = ALU_CMP;
          PCSource    = 2'b01;
          PCWrite     = br_taken;
        end
        JUMP: begin
          PCSource = 2'b10;
          PCWrite  = 1'b1;
        end
        EXC_EPC: begin
          ALUSrcB     = 2'b01;
          ALU_Control = ALU_SUB;
          EPCWrite    = 1'b1;
        end
        EXC_JMP: begin
          PCSource = 2'b11;
          PCWrite  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
